// File: rtl/pipe_lane_ctrl.sv
// Multi-lane PIPE control: shared PowerDown/Rate/receiver-detect with per-lane PhyStatus handshake.
// Optional macro PIPE_LANE_MASK_EN keeps lanes without a detected receiver in electrical idle.

module pipe_lane (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       clr_ack,
    input  logic       cap_ack,
    input  logic       clr_det,
    input  logic       cap_det,
    input  logic       phy_status,
    input  logic [2:0] rx_status,
    input  logic       idle_all,
    input  logic       mask_hold,
    output logic       ack,
    output logic       found,
    output logic       tx_elec_idle
);
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            ack   <= 1'b0;
            found <= 1'b0;
        end else begin
            if (clr_ack)
                ack <= 1'b0;
            else if (cap_ack)
                ack <= ack | phy_status;
            // only the first PhyStatus of a detect reports the receiver status
            if (clr_det)
                found <= 1'b0;
            else if (cap_det && phy_status && !ack)
                found <= (rx_status == 3'b011);
        end
    end

    assign tx_elec_idle = idle_all | (mask_hold & ~found);
endmodule

module pipe_lane_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   pclk,
    input  logic                   reset_n,
    input  logic [4:0]             substate,
    input  logic [2:0]             generation,
    input  logic                   ElecIdle_req,
    input  logic                   Detect_req,
    input  logic [NUM_LANES-1:0]   PhyStatus,
    input  logic [3*NUM_LANES-1:0] RxStatus,
    output logic [3:0]             PowerDown,
    output logic [1:0]             Rate,
    output logic                   TxDetectRx_Loopback,
    output logic [NUM_LANES-1:0]   TxElecIdle,
    output logic                   Detect_done,
    output logic [NUM_LANES-1:0]   Detect_lanes,
    output logic                   Detect_timeout,
    output logic                   Busy
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {READY, ACK_WAIT, DETECT, DET_END} state_t;

    state_t               state, state_nxt;
    logic [3:0]           pd_nxt, tgt_pd;
    logic [1:0]           rate_nxt, tgt_rate;
    logic                 loop_nxt, done_nxt, tmo_nxt, start_det;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_LANES-1:0] ack;
    logic                 all_ack, cnt_tmo, idle_all, mask_hold;

    assign tgt_pd = (substate <= 5'd1) ? 4'd2 : 4'd0;
    always_comb begin
        case (generation)
            3'd2:    tgt_rate = 2'd1;
            3'd3:    tgt_rate = 2'd2;
            default: tgt_rate = 2'd0;
        endcase
    end

    // completion includes this cycle's strobes so the exit happens on the same edge
    assign all_ack = &(ack | PhyStatus);
    assign cnt_tmo = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        pd_nxt    = PowerDown;
        rate_nxt  = Rate;
        loop_nxt  = TxDetectRx_Loopback;
        done_nxt  = 1'b0;
        tmo_nxt   = 1'b0;
        start_det = 1'b0;
        case (state)
            READY: begin
                if (tgt_pd != PowerDown) begin
                    pd_nxt    = tgt_pd;
                    state_nxt = ACK_WAIT;
                end else if (tgt_rate != Rate && PowerDown == 4'd0) begin
                    rate_nxt  = tgt_rate;
                    state_nxt = ACK_WAIT;
                end else if (Detect_req && PowerDown == 4'd2) begin
                    loop_nxt  = 1'b1;
                    start_det = 1'b1;
                    state_nxt = DETECT;
                end
            end
            ACK_WAIT: begin
                if (all_ack) begin
                    state_nxt = READY;
                end else if (cnt_tmo) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = READY;
                end
            end
            DETECT: begin
                if (all_ack || cnt_tmo) begin
                    tmo_nxt   = !all_ack;
                    done_nxt  = 1'b1;
                    loop_nxt  = 1'b0;
                    state_nxt = DET_END;
                end
            end
            default: state_nxt = READY;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state               <= ACK_WAIT;
            PowerDown           <= 4'd2;
            Rate                <= 2'd0;
            TxDetectRx_Loopback <= 1'b0;
            Detect_done         <= 1'b0;
            Detect_timeout      <= 1'b0;
            cnt                 <= '0;
        end else begin
            state               <= state_nxt;
            PowerDown           <= pd_nxt;
            Rate                <= rate_nxt;
            TxDetectRx_Loopback <= loop_nxt;
            Detect_done         <= done_nxt;
            Detect_timeout      <= tmo_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if ((state == ACK_WAIT || state == DETECT) && cnt != CNT_W'(TIMEOUT_CYC))
                cnt <= cnt + 1'b1;
        end
    end

`ifdef PIPE_LANE_MASK_EN
    logic det_seen;
    always_ff @(posedge pclk) begin
        if (!reset_n)
            det_seen <= 1'b0;
        else if (done_nxt)
            det_seen <= 1'b1;
    end
    assign mask_hold = det_seen;
`else
    assign mask_hold = 1'b0;
`endif

    assign Busy     = (state != READY);
    assign idle_all = ElecIdle_req || (substate <= 5'd1) || (PowerDown != 4'd0) || Busy;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pipe_lane u_lane (
            .pclk         (pclk),
            .reset_n      (reset_n),
            .clr_ack      (state == READY),
            .cap_ack      (state == ACK_WAIT || state == DETECT),
            .clr_det      (start_det),
            .cap_det      (state == DETECT),
            .phy_status   (PhyStatus[i]),
            .rx_status    (RxStatus[3*i +: 3]),
            .idle_all     (idle_all),
            .mask_hold    (mask_hold),
            .ack          (ack[i]),
            .found        (Detect_lanes[i]),
            .tx_elec_idle (TxElecIdle[i])
        );
    end
endmodule

// File: tb/tb_pipe_lane_ctrl.sv
// Directed bench for pipe_lane_ctrl: reset ack, detect, detect timeout, power/rate, idle, reset abort, lane mask.

module tb_pipe_lane_ctrl;
    localparam int NL = 4;
    localparam int TC = 32;

    logic          pclk = 1'b0;
    logic          reset_n;
    logic [4:0]    substate;
    logic [2:0]    generation;
    logic          ElecIdle_req, Detect_req;
    logic [NL-1:0] PhyStatus;
    logic [3*NL-1:0] RxStatus;
    logic [3:0]    PowerDown;
    logic [1:0]    Rate;
    logic          TxDetectRx_Loopback, Detect_done, Detect_timeout, Busy;
    logic [NL-1:0] TxElecIdle, Detect_lanes;
    logic [9:0]    ctl;

    int vecs = 0;
    int errs = 0;
    logic          seen_m = 1'b0;
    logic [NL-1:0] lanes_m = '0;

    pipe_lane_ctrl #(.NUM_LANES(NL), .TIMEOUT_CYC(TC)) dut (
        .pclk(pclk), .reset_n(reset_n), .substate(substate), .generation(generation),
        .ElecIdle_req(ElecIdle_req), .Detect_req(Detect_req), .PhyStatus(PhyStatus),
        .RxStatus(RxStatus), .PowerDown(PowerDown), .Rate(Rate),
        .TxDetectRx_Loopback(TxDetectRx_Loopback), .TxElecIdle(TxElecIdle),
        .Detect_done(Detect_done), .Detect_lanes(Detect_lanes),
        .Detect_timeout(Detect_timeout), .Busy(Busy)
    );

    always #5 pclk = ~pclk;

    // {PowerDown, Rate, Loopback, Busy, Detect_done, Detect_timeout}
    assign ctl = {PowerDown, Rate, TxDetectRx_Loopback, Busy, Detect_done, Detect_timeout};

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    // expected idle for an active L0 lane set given the detect history
    function automatic logic [NL-1:0] idle_exp();
`ifdef PIPE_LANE_MASK_EN
        return ~lanes_m & {NL{seen_m}};
`else
        return '0;
`endif
    endfunction

    task automatic test_reset;
        reset_n = 1'b0; substate = 5'd0; generation = 3'd1;
        ElecIdle_req = 1'b0; Detect_req = 1'b0; PhyStatus = '0; RxStatus = '0;
        tick; tick;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0100}) begin errs++; $display("FAIL rst_ctl: got %b want %b", ctl, {4'd2, 2'd0, 4'b0100}); end
        vecs++; if (TxElecIdle !== 4'hf || Detect_lanes !== 4'h0) begin errs++; $display("FAIL rst_lanes: got idle=%h lanes=%h want f 0", TxElecIdle, Detect_lanes); end
        reset_n = 1'b1;
        tick; tick;
        vecs++; if (Busy !== 1'b1) begin errs++; $display("FAIL rst_wait_busy: got %b want 1", Busy); end
        PhyStatus = 4'hf;
        tick;
        PhyStatus = '0;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0000}) begin errs++; $display("FAIL rst_ready: got %b want %b", ctl, {4'd2, 2'd0, 4'b0000}); end
        vecs++; if (TxElecIdle !== 4'hf) begin errs++; $display("FAIL rst_idle: got %h want f", TxElecIdle); end
    endtask

    task automatic test_detect;
        Detect_req = 1'b1;
        tick;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b1100}) begin errs++; $display("FAIL det_start: got %b want %b", ctl, {4'd2, 2'd0, 4'b1100}); end
        Detect_req = 1'b0;
        PhyStatus = 4'b0011; RxStatus = {3'b000, 3'b000, 3'b011, 3'b011};
        tick;
        vecs++; if (Detect_lanes !== 4'b0011 || ctl !== {4'd2, 2'd0, 4'b1100}) begin errs++; $display("FAIL det_partial: got lanes=%b ctl=%b want 0011 %b", Detect_lanes, ctl, {4'd2, 2'd0, 4'b1100}); end
        PhyStatus = 4'b1101; RxStatus = '0;
        tick;
        PhyStatus = '0;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0110} || Detect_lanes !== 4'b0011) begin errs++; $display("FAIL det_end: got ctl=%b lanes=%b want %b 0011", ctl, Detect_lanes, {4'd2, 2'd0, 4'b0110}); end
        tick;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0000} || Detect_lanes !== 4'b0011) begin errs++; $display("FAIL det_ready: got ctl=%b lanes=%b want %b 0011", ctl, Detect_lanes, {4'd2, 2'd0, 4'b0000}); end
        lanes_m = 4'b0011; seen_m = 1'b1;
    endtask

    task automatic test_detect_timeout;
        int early;
        early = 0;
        Detect_req = 1'b1;
        tick;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b1100} || Detect_lanes !== 4'h0) begin errs++; $display("FAIL tmo_start: got ctl=%b lanes=%b want %b 0000", ctl, Detect_lanes, {4'd2, 2'd0, 4'b1100}); end
        Detect_req = 1'b0;
        PhyStatus = 4'b0111; RxStatus = {4{3'b011}};
        tick;
        PhyStatus = '0;
        vecs++; if (Detect_lanes !== 4'b0111) begin errs++; $display("FAIL tmo_lanes: got %b want 0111", Detect_lanes); end
        for (int k = 2; k < TC; k++) begin
            tick;
            if (Detect_done || Detect_timeout || !TxDetectRx_Loopback) early++;
        end
        vecs++; if (early !== 0) begin errs++; $display("FAIL tmo_early: got %0d early cycles want 0", early); end
        tick;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0111} || Detect_lanes !== 4'b0111) begin errs++; $display("FAIL tmo_fire: got ctl=%b lanes=%b want %b 0111", ctl, Detect_lanes, {4'd2, 2'd0, 4'b0111}); end
        tick;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0000}) begin errs++; $display("FAIL tmo_ready: got %b want %b", ctl, {4'd2, 2'd0, 4'b0000}); end
        lanes_m = 4'b0111;
    endtask

    task automatic test_power_rate;
        substate = 5'd4; generation = 3'd3;
        tick;
        vecs++; if (ctl !== {4'd0, 2'd0, 4'b0100} || TxElecIdle !== 4'hf) begin errs++; $display("FAIL pr_pd: got ctl=%b idle=%h want %b f", ctl, TxElecIdle, {4'd0, 2'd0, 4'b0100}); end
        PhyStatus = 4'hf;
        tick;
        PhyStatus = '0;
        vecs++; if (ctl !== {4'd0, 2'd0, 4'b0000} || TxElecIdle !== idle_exp()) begin errs++; $display("FAIL pr_mid: got ctl=%b idle=%h want %b %h", ctl, TxElecIdle, {4'd0, 2'd0, 4'b0000}, idle_exp()); end
        tick;
        vecs++; if (ctl !== {4'd0, 2'd2, 4'b0100} || TxElecIdle !== 4'hf) begin errs++; $display("FAIL pr_rate: got ctl=%b idle=%h want %b f", ctl, TxElecIdle, {4'd0, 2'd2, 4'b0100}); end
        PhyStatus = 4'b1010;
        tick;
        vecs++; if (Busy !== 1'b1) begin errs++; $display("FAIL pr_partial: got busy=%b want 1", Busy); end
        PhyStatus = 4'b0101;
        tick;
        PhyStatus = '0;
        vecs++; if (ctl !== {4'd0, 2'd2, 4'b0000} || TxElecIdle !== idle_exp()) begin errs++; $display("FAIL pr_done: got ctl=%b idle=%h want %b %h", ctl, TxElecIdle, {4'd0, 2'd2, 4'b0000}, idle_exp()); end
        Detect_req = 1'b1;
        tick;
        Detect_req = 1'b0;
        vecs++; if (ctl !== {4'd0, 2'd2, 4'b0000}) begin errs++; $display("FAIL pr_no_det_p0: got %b want %b", ctl, {4'd0, 2'd2, 4'b0000}); end
    endtask

    task automatic test_elec_idle;
        substate = 5'd10;
        tick;
        ElecIdle_req = 1'b1;
        tick;
        vecs++; if (TxElecIdle !== 4'hf || ctl !== {4'd0, 2'd2, 4'b0000}) begin errs++; $display("FAIL ei_on: got idle=%h ctl=%b want f %b", TxElecIdle, ctl, {4'd0, 2'd2, 4'b0000}); end
        ElecIdle_req = 1'b0;
        tick;
        vecs++; if (TxElecIdle !== idle_exp()) begin errs++; $display("FAIL ei_off: got %h want %h", TxElecIdle, idle_exp()); end
    endtask

    task automatic test_reset_mid_detect;
        substate = 5'd0;
        tick;
        vecs++; if (ctl !== {4'd2, 2'd2, 4'b0100}) begin errs++; $display("FAIL rm_p1: got %b want %b", ctl, {4'd2, 2'd2, 4'b0100}); end
        PhyStatus = 4'hf;
        tick;
        PhyStatus = '0;
        Detect_req = 1'b1;
        tick;
        Detect_req = 1'b0;
        vecs++; if (ctl !== {4'd2, 2'd2, 4'b1100}) begin errs++; $display("FAIL rm_det: got %b want %b", ctl, {4'd2, 2'd2, 4'b1100}); end
        PhyStatus = 4'b0001; RxStatus = {3'b000, 3'b000, 3'b000, 3'b011};
        tick;
        PhyStatus = '0;
        vecs++; if (Detect_lanes !== 4'b0001) begin errs++; $display("FAIL rm_lane0: got %b want 0001", Detect_lanes); end
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        seen_m = 1'b0; lanes_m = '0;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0100} || Detect_lanes !== 4'h0 || TxElecIdle !== 4'hf) begin errs++; $display("FAIL rm_reset: got ctl=%b lanes=%b idle=%h want %b 0000 f", ctl, Detect_lanes, TxElecIdle, {4'd2, 2'd0, 4'b0100}); end
        tick;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0100}) begin errs++; $display("FAIL rm_no_done: got %b want %b", ctl, {4'd2, 2'd0, 4'b0100}); end
        PhyStatus = 4'hf;
        tick;
        PhyStatus = '0;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0000}) begin errs++; $display("FAIL rm_ready: got %b want %b", ctl, {4'd2, 2'd0, 4'b0000}); end
    endtask

    task automatic test_lane_mask;
        Detect_req = 1'b1;
        tick;
        Detect_req = 1'b0;
        PhyStatus = 4'hf; RxStatus = {3'b000, 3'b011, 3'b000, 3'b011};
        tick;
        PhyStatus = '0;
        vecs++; if (ctl !== {4'd2, 2'd0, 4'b0110} || Detect_lanes !== 4'b0101) begin errs++; $display("FAIL lm_det: got ctl=%b lanes=%b want %b 0101", ctl, Detect_lanes, {4'd2, 2'd0, 4'b0110}); end
        lanes_m = 4'b0101; seen_m = 1'b1;
        tick;
        substate = 5'd10; generation = 3'd1;
        tick;
        vecs++; if (ctl !== {4'd0, 2'd0, 4'b0100}) begin errs++; $display("FAIL lm_pd: got %b want %b", ctl, {4'd0, 2'd0, 4'b0100}); end
        PhyStatus = 4'hf;
        tick;
        PhyStatus = '0;
        vecs++; if (ctl !== {4'd0, 2'd0, 4'b0000} || TxElecIdle !== idle_exp()) begin errs++; $display("FAIL lm_idle: got ctl=%b idle=%b want %b %b", ctl, TxElecIdle, {4'd0, 2'd0, 4'b0000}, idle_exp()); end
    endtask

    initial begin
        test_reset;
        test_detect;
        test_detect_timeout;
        test_power_rate;
        test_elec_idle;
        test_reset_mid_detect;
        test_lane_mask;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
